// File: rtl/strassen_stream_mult.sv
// One-level Strassen multiplier for an N x N tile with element-serial valid/ready streams.
// A single MAC computes the seven half-size products; each finished Q element is folded into C.
module strassen_stream_mult #(
    parameter int N      = 8,
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             done
);

    localparam int H  = N / 2;
    localparam int NN = N * N;
    localparam int IW = $clog2(2 * NN);
    localparam int OW = $clog2(NN);
    localparam int HW = (H > 1) ? $clog2(H) : 1;

    localparam logic [IW-1:0] LD_LAST  = IW'(2 * NN - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NN - 1);
    localparam logic [HW-1:0] H_MAX    = HW'(H - 1);
    localparam logic [2:0]    K_LAST   = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MULT, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ld_idx_q, ld_idx_d;
    logic [OW-1:0]    out_idx_q, out_idx_d;
    logic [2:0]       k_q, k_d;
    logic [HW-1:0]    i_q, i_d, j_q, j_d, l_q, l_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] c_q [NN];
    logic [ACC_W-1:0] c_d [NN];
    logic [DW-1:0]    mem_q [2*NN];

    logic [ACC_W-1:0] t_op, s_op, q_val;

    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v);
        if (SIGNED != 0) return {{(ACC_W-DW){v[DW-1]}}, v};
        else             return {{(ACC_W-DW){1'b0}}, v};
    endfunction

    function automatic logic [ACC_W-1:0] a_at(input int r, input int c);
        return ext(mem_q[r*N + c]);
    endfunction

    function automatic logic [ACC_W-1:0] b_at(input int r, input int c);
        return ext(mem_q[NN + r*N + c]);
    endfunction

    // NOTE: the A/B element store has no reset; every location is rewritten by LOAD before MULT reads it.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD && in_valid) mem_q[ld_idx_q] <= in_data;
    end

    // Strassen operand pairs T_k / S_k for the current (i, l) and (l, j) quadrant elements.
    always_comb begin
        int ii, jj, ll;
        logic [ACC_W-1:0] a11, a12, a21, a22, b11, b12, b21, b22;
        ii  = int'(i_q);
        jj  = int'(j_q);
        ll  = int'(l_q);
        a11 = a_at(ii, ll);
        a12 = a_at(ii, ll + H);
        a21 = a_at(ii + H, ll);
        a22 = a_at(ii + H, ll + H);
        b11 = b_at(ll, jj);
        b12 = b_at(ll, jj + H);
        b21 = b_at(ll + H, jj);
        b22 = b_at(ll + H, jj + H);
        t_op = '0;
        s_op = '0;
        unique case (k_q)
            3'd0:    begin t_op = a11 + a22; s_op = b11 + b22; end
            3'd1:    begin t_op = a21 + a22; s_op = b11;       end
            3'd2:    begin t_op = a11;       s_op = b12 - b22; end
            3'd3:    begin t_op = a22;       s_op = b21 - b11; end
            3'd4:    begin t_op = a11 + a12; s_op = b22;       end
            3'd5:    begin t_op = a21 - a11; s_op = b11 + b12; end
            3'd6:    begin t_op = a12 - a22; s_op = b21 + b22; end
            default: begin t_op = '0;        s_op = '0;        end
        endcase
        q_val = ((l_q == '0) ? '0 : acc_q) + t_op * s_op;
    end

    // NOTE: every variable written in this process gets a default first, so no latches are inferred.
    always_comb begin
        state_d   = state_q;
        ld_idx_d  = ld_idx_q;
        out_idx_d = out_idx_q;
        k_d       = k_q;
        i_d       = i_q;
        j_d       = j_q;
        l_d       = l_q;
        acc_d     = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    ld_idx_d = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (ld_idx_q == LD_LAST) begin
                        ld_idx_d = '0;
                        state_d  = S_MULT;
                        k_d      = '0;
                        i_d      = '0;
                        j_d      = '0;
                        l_d      = '0;
                    end else begin
                        ld_idx_d = ld_idx_q + 1'b1;
                    end
                end
            end
            S_MULT: begin
                acc_d = q_val;
                if (l_q != H_MAX) l_d = l_q + 1'b1;
                else begin
                    l_d = '0;
                    if (j_q != H_MAX) j_d = j_q + 1'b1;
                    else begin
                        j_d = '0;
                        if (i_q != H_MAX) i_d = i_q + 1'b1;
                        else begin
                            i_d = '0;
                            if (k_q != K_LAST) k_d = k_q + 1'b1;
                            else begin
                                state_d   = S_DRAIN;
                                out_idx_d = '0;
                            end
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (out_idx_q == OUT_LAST) begin
                        state_d   = S_IDLE;
                        out_idx_d = '0;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fold a finished Q_k[i][j] into the C quadrants with its +1/-1 coefficients.
    always_comb begin
        int r11, r12, r21, r22;
        r11 = int'(i_q) * N + int'(j_q);
        r12 = r11 + H;
        r21 = r11 + H * N;
        r22 = r21 + H;
        for (int x = 0; x < NN; x++) c_d[x] = c_q[x];
        if (state_q == S_IDLE && start) begin
            for (int x = 0; x < NN; x++) c_d[x] = '0;
        end else if (state_q == S_MULT && l_q == H_MAX) begin
            unique case (k_q)
                3'd0:    begin c_d[r11] = c_q[r11] + q_val; c_d[r22] = c_q[r22] + q_val; end
                3'd1:    begin c_d[r21] = c_q[r21] + q_val; c_d[r22] = c_q[r22] - q_val; end
                3'd2:    begin c_d[r12] = c_q[r12] + q_val; c_d[r22] = c_q[r22] + q_val; end
                3'd3:    begin c_d[r11] = c_q[r11] + q_val; c_d[r21] = c_q[r21] + q_val; end
                3'd4:    begin c_d[r11] = c_q[r11] - q_val; c_d[r12] = c_q[r12] + q_val; end
                3'd5:    c_d[r22] = c_q[r22] + q_val;
                3'd6:    c_d[r11] = c_q[r11] + q_val;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ld_idx_q  <= '0;
            out_idx_q <= '0;
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            l_q       <= '0;
            acc_q     <= '0;
            for (int x = 0; x < NN; x++) c_q[x] <= '0;
        end else begin
            state_q   <= state_d;
            ld_idx_q  <= ld_idx_d;
            out_idx_q <= out_idx_d;
            k_q       <= k_d;
            i_q       <= i_d;
            j_q       <= j_d;
            l_q       <= l_d;
            acc_q     <= acc_d;
            for (int x = 0; x < NN; x++) c_q[x] <= c_d[x];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_DRAIN);
    assign out_data  = (state_q == S_DRAIN) ? c_q[out_idx_q] : '0;
    assign done      = (state_q == S_DRAIN) && out_ready && (out_idx_q == OUT_LAST);

endmodule

// File: tb/tb_strassen_stream_mult.sv
// Directed bench for strassen_stream_mult: unsigned N=4, signed N=4 and unsigned N=8 instances
// share the input stream; only the selected instance is started for each tile.
module tb_strassen_stream_mult;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [2:0]            start_v;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  out_ready;
    logic [2:0]            busy_w, in_ready_w, out_valid_w, done_w;
    logic [2:0][23:0]      out_data_w;

    int                    vectors    = 0;
    int                    miscompares = 0;
    int                    cyc        = 0;
    int                    sel        = 0;
    int                    hs_cyc     = 0;
    logic [7:0]            ma [64];
    logic [7:0]            mb [64];
    logic [23:0]           exp_c [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    strassen_stream_mult #(.N(4), .DW(8), .ACC_W(24), .SIGNED(0)) u_dut_u4 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_w[0]),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]), .done(done_w[0])
    );

    strassen_stream_mult #(.N(4), .DW(8), .ACC_W(24), .SIGNED(1)) u_dut_s4 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_w[1]),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]), .done(done_w[1])
    );

    strassen_stream_mult #(.N(8), .DW(8), .ACC_W(24), .SIGNED(0)) u_dut_u8 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_w[2]),
        .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_data(in_data),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_data(out_data_w[2]), .done(done_w[2])
    );

    // Plain triple-loop reference product, truncated to 24 bits.
    task automatic build_expected(input int n, input bit sgn);
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                int s;
                s = 0;
                for (int t = 0; t < n; t++) begin
                    int av, bv;
                    av = sgn ? int'($signed(ma[r*n+t])) : int'(ma[r*n+t]);
                    bv = sgn ? int'($signed(mb[t*n+c])) : int'(mb[t*n+c]);
                    s += av * bv;
                end
                exp_c[r*n+c] = 24'(s);
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int x = 0; x < n*n; x++) begin
            ma[x] = 8'($urandom);
            mb[x] = 8'($urandom);
        end
    endtask

    task automatic fill_const(input int n, input logic [7:0] va, input logic [7:0] vb);
        for (int x = 0; x < n*n; x++) begin
            ma[x] = va;
            mb[x] = vb;
        end
    endtask

    task automatic start_tile();
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        vectors++;
        if (in_ready_w[sel] !== 1'b1 || busy_w[sel] !== 1'b1)
            $display("FAIL load_entry dut%0d: in_ready=%b busy=%b, required 1/1", sel, in_ready_w[sel], busy_w[sel]);
        if (in_ready_w[sel] !== 1'b1 || busy_w[sel] !== 1'b1) miscompares++;
    endtask

    task automatic load_tile(input int n, input bit gaps);
        int nn;
        nn = n * n;
        for (int b = 0; b < 2*nn; b++) begin
            int waited;
            if (gaps) begin
                while ($urandom_range(1, 0) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = (b < nn) ? ma[b] : mb[b-nn];
            waited   = 0;
            while (in_ready_w[sel] !== 1'b1 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 100) begin
                vectors++;
                miscompares++;
                $display("FAIL load_timeout dut%0d beat %0d: in_ready=%b, required 1", sel, b, in_ready_w[sel]);
                in_valid = 1'b0;
                return;
            end
            hs_cyc = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (in_ready_w[sel] !== 1'b0 || out_valid_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) begin
            miscompares++;
            $display("FAIL mult_entry dut%0d: in_ready=%b out_valid=%b busy=%b, required 0/0/1",
                     sel, in_ready_w[sel], out_valid_w[sel], busy_w[sel]);
        end
    endtask

    // ready_mode 0: always ready; 1: out_ready toggles every 3 cycles.
    task automatic drain_tile(input int n, input int ready_mode, input bit hold_start);
        int idx, dones, guard, exp_lat;
        bit lat_seen, have_held;
        logic [23:0] held;
        idx = 0; dones = 0; guard = 0; lat_seen = 0; have_held = 0; held = '0;
        exp_lat = 7 * (n/2) * (n/2) * (n/2) + 1;
        while (idx < n*n && guard < 5000) begin
            out_ready = (ready_mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
            #1;
            if (out_valid_w[sel] === 1'b1 && !lat_seen) begin
                lat_seen = 1;
                vectors++;
                if (cyc - hs_cyc != exp_lat) begin
                    miscompares++;
                    $display("FAIL latency dut%0d: %0d cycles, required %0d", sel, cyc - hs_cyc, exp_lat);
                end
            end
            if (have_held) begin
                have_held = 0;
                vectors++;
                if (out_data_w[sel] !== held) begin
                    miscompares++;
                    $display("FAIL stall_hold dut%0d idx %0d: out_data=%h, required %h", sel, idx, out_data_w[sel], held);
                end
            end
            if (done_w[sel] === 1'b1) dones++;
            if (out_valid_w[sel] === 1'b1 && out_ready) begin
                vectors++;
                if (out_data_w[sel] !== exp_c[idx]) begin
                    miscompares++;
                    $display("FAIL c_elem dut%0d idx %0d: out_data=%h, required %h", sel, idx, out_data_w[sel], exp_c[idx]);
                end
                vectors++;
                if (done_w[sel] !== (idx == n*n-1)) begin
                    miscompares++;
                    $display("FAIL done_flag dut%0d idx %0d: done=%b, required %b", sel, idx, done_w[sel], idx == n*n-1);
                end
                idx++;
            end else if (out_valid_w[sel] === 1'b1) begin
                held      = out_data_w[sel];
                have_held = 1;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        if (hold_start) start_v[sel] = 1'b0;
        vectors++;
        if (idx != n*n) begin
            miscompares++;
            $display("FAIL drain_count dut%0d: %0d handshakes, required %0d", sel, idx, n*n);
        end
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL done_pulses dut%0d: %0d pulses, required 1", sel, dones);
        end
        #1;
        vectors++;
        if (busy_w[sel] !== 1'b0 || out_valid_w[sel] !== 1'b0 || out_data_w[sel] !== 24'h0) begin
            miscompares++;
            $display("FAIL idle_after dut%0d: busy=%b out_valid=%b out_data=%h, required 0/0/0",
                     sel, busy_w[sel], out_valid_w[sel], out_data_w[sel]);
        end
        @(negedge clk);
        vectors++;
        if (busy_w[sel] !== 1'b0) begin
            miscompares++;
            $display("FAIL stay_idle dut%0d: busy=%b, required 0", sel, busy_w[sel]);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start_v   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (busy_w[d] !== 1'b0 || in_ready_w[d] !== 1'b0 || out_valid_w[d] !== 1'b0 ||
                done_w[d] !== 1'b0 || out_data_w[d] !== 24'h0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: busy=%b in_ready=%b out_valid=%b done=%b out_data=%h, required all 0",
                         d, busy_w[d], in_ready_w[d], out_valid_w[d], done_w[d], out_data_w[d]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        sel = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r*4+c] = (r == c) ? 8'd1 : 8'd0;
                mb[r*4+c] = 8'(4*r + c);
                exp_c[r*4+c] = 24'(4*r + c);
            end
        start_tile();
        load_tile(4, 0);
        drain_tile(4, 0, 0);
    endtask

    task automatic test_all_max();
        sel = 0;
        fill_const(4, 8'hFF, 8'hFF);
        for (int x = 0; x < 16; x++) exp_c[x] = 24'h03F804;
        start_tile();
        load_tile(4, 0);
        drain_tile(4, 0, 0);
    endtask

    task automatic test_signed();
        sel = 1;
        fill_const(4, 8'h80, 8'h80);
        for (int x = 0; x < 16; x++) exp_c[x] = 24'h010000;
        start_tile();
        load_tile(4, 0);
        drain_tile(4, 0, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r*4+c] = (r == c) ? 8'hFF : 8'h00;
                mb[r*4+c] = (r == c) ? 8'h01 : 8'h00;
                exp_c[r*4+c] = (r == c) ? 24'hFFFFFF : 24'h0;
            end
        start_tile();
        load_tile(4, 0);
        drain_tile(4, 0, 0);
    endtask

    task automatic test_random_stalls();
        sel = 0;
        fill_random(4);
        build_expected(4, 0);
        start_tile();
        load_tile(4, 1);
        drain_tile(4, 1, 0);
    endtask

    task automatic test_abort();
        int leaks;
        sel = 0;
        fill_random(4);
        start_tile();
        load_tile(4, 0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (busy_w[0] !== 1'b0 || out_valid_w[0] !== 1'b0 || in_ready_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b out_valid=%b in_ready=%b, required 0/0/0",
                     busy_w[0], out_valid_w[0], in_ready_w[0]);
        end
        @(negedge clk);
        rst   = 1'b0;
        leaks = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) leaks++;
        end
        vectors++;
        if (leaks != 0) begin
            miscompares++;
            $display("FAIL abort_leak: %0d active cycles after reset, required 0", leaks);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r*4+c] = (r == c) ? 8'd1 : 8'd0;
                mb[r*4+c] = (r == c) ? 8'd2 : 8'd0;
                exp_c[r*4+c] = (r == c) ? 24'd2 : 24'd0;
            end
        start_tile();
        load_tile(4, 0);
        drain_tile(4, 0, 0);
    endtask

    task automatic test_n8_start_held();
        sel = 2;
        fill_random(8);
        build_expected(8, 0);
        start_tile();
        load_tile(8, 0);
        start_v[2] = 1'b1;
        drain_tile(8, 0, 1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_max();
        test_signed();
        test_random_stalls();
        test_abort();
        test_n8_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

endmodule
